up_down_counter_controller: RTL and testbench
=============================================

UP_DOWN_COUNTER_CONTROLLER -- requirements
Module: up_down_counter_controller

Interface
REQ-001 Parameter: CNT_W, 4, width of the controlled counter and of all limit/count buses.
REQ-002 Clk_In  input  1  system clock; controller logic on rising edge; counter updates on falling edge.
REQ-003 Reset_In  input  1  reset, synchronous, active-high.
REQ-004 Start_In  input  1  start request, sampled on rising edge; honoured only in IDLE.
REQ-005 Abort_In  input  1  abandon current run, return to IDLE.
REQ-006 Pause_In  input  1  level; freezes counter and controller state while high.
REQ-007 Mode_In  input  2  00 up-once, 01 down-once, 10 ping-pong continuous, 11 ping-pong N round trips.
REQ-008 Low_Limit_In  input  CNT_W  lower turn-around value.
REQ-009 High_Limit_In  input  CNT_W  upper turn-around value.
REQ-010 Cycles_In  input  CNT_W  round-trip count N for mode 11.
REQ-011 Count_In  input  CNT_W  current counter value, sampled on rising edge.
REQ-012 Start_Stopb_Out  output  1  counter enable: 1 count, 0 hold.
REQ-013 Up_Downb_Out  output  1  counter direction: 1 up, 0 down.
REQ-014 Busy_Out  output  1  high in any state other than IDLE.
REQ-015 Done_Out  output  1  one-cycle pulse on normal completion.
REQ-016 Error_Out  output  1  sticky configuration error flag.
REQ-017 Trip_Count_Out  output  CNT_W  round trips completed in the current run.

Function
REQ-018 States SHALL be IDLE, SEEK, UP, DOWN; all outputs SHALL be registered, and values written at a transition SHALL reflect the decision taken at that edge.
REQ-019 IDLE: Start_Stopb_Out=0; on Start_In=1, latch Mode, Low, High, Cycles and clear Trip_Count_Out and Error_Out.
REQ-020 Start with Low_Limit_In>=High_Limit_In, or with Mode 11 and Cycles_In=0, SHALL set Error_Out=1 and remain in IDLE.
REQ-021 Otherwise go to SEEK; target = latched High for mode 01, latched Low for all other modes.
REQ-022 SEEK: if Count_In<target, drive enable=1 and dir=1; if greater, drive enable=1 and dir=0; if equal, go to DOWN (mode 01) or UP (other modes), driving enable=1 with the matching dir.
REQ-023 UP: while Count_In!=High, keep enable=1 and dir=1.
REQ-024 UP, Count_In==High: in mode 00, complete (REQ-027); otherwise go to DOWN with dir=0.
REQ-025 DOWN: while Count_In!=Low, keep enable=1 and dir=0.
REQ-026 DOWN, Count_In==Low: mode 01 completes; mode 10 goes to UP; mode 11 increments Trip_Count_Out, then completes if the new value equals latched Cycles, else goes to UP.
REQ-027 Completion SHALL drive Start_Stopb_Out=0, pulse Done_Out for exactly one cycle, and return to IDLE, so the counter holds exactly at the final limit with no overshoot.
REQ-028 Decisions SHALL use Count_In at the current edge; the counter applies the new control at the following falling edge, so turn-around happens without the counter passing a limit.
REQ-029 Pause_In=1 in SEEK/UP/DOWN SHALL force Start_Stopb_Out=0 and block all state and Trip_Count transitions; on release, operation resumes from the same state.
REQ-030 Abort_In=1 in any non-IDLE state SHALL go to IDLE with Start_Stopb_Out=0 and no Done pulse; Trip_Count_Out is retained.
REQ-031 Priority SHALL be Reset_In > Abort_In > Pause_In > normal sequencing; Start_In outside IDLE SHALL be ignored.
REQ-032 Mode 10 SHALL run until Abort_In; Trip_Count_Out SHALL increment per round trip, wrapping modulo 2^CNT_W.
REQ-033 Limit inputs changed mid-run SHALL have no effect until the next start.

Reset
REQ-034 On Reset_In=1 at a rising edge: state=IDLE, Start_Stopb_Out=0, Up_Downb_Out=1, Busy_Out=0, Done_Out=0, Error_Out=0, Trip_Count_Out=0.
REQ-035 Reset mid-run SHALL take precedence over all inputs; the counter is left holding its current value.

Verification
REQ-036 Mode 00, Low=3, High=9, counter at 0 -> SEEK up 0..3, UP 3..9, Done pulse once, counter holds 9.
REQ-037 Mode 01, Low=2, High=12, counter at 15 -> SEEK down to 12, DOWN to 2, Done, counter holds 2.
REQ-038 Mode 11, Low=4, High=6, Cycles=2 -> count sequence 4,5,6,5,4,5,6,5,4; Trip_Count_Out 1 then 2; Done once.
REQ-039 Low=7, High=7 on Start -> Error_Out=1, Busy_Out=0, Start_Stopb_Out stays 0; the next valid start clears Error_Out.
REQ-040 Mode 10, Low=0, High=15, Pause for 5 cycles at count 8 -> count holds 8, direction resumes unchanged; Abort -> IDLE, no Done.
REQ-041 Reset asserted in DOWN at count 5 -> next edge all outputs at reset values; counter stays at 5.

Source files
------------

// File: rtl/up_down_counter_controller.sv
// up_down_counter_controller
//   Sequences an external up/down counter between a latched low and high
//   limit. Control decisions are taken on the rising edge of Clk_In from the
//   sampled Count_In; the counter applies the new enable/direction on the
//   following falling edge, so every turn-around and stop lands exactly on a
//   limit without overshoot.
//
// Ports
//   Clk_In           system clock (controller on rising edge)
//   Reset_In         synchronous active-high reset
//   Start_In         start request, honoured only in IDLE
//   Abort_In         abandon the current run, back to IDLE without Done
//   Pause_In         level; holds counter and controller while high
//   Mode_In          00 up-once, 01 down-once, 10 ping-pong, 11 N round trips
//   Low_Limit_In     lower turn-around value
//   High_Limit_In    upper turn-around value
//   Cycles_In        round-trip count for mode 11
//   Count_In         current counter value
//   Start_Stopb_Out  counter enable (1 count, 0 hold)
//   Up_Downb_Out     counter direction (1 up, 0 down)
//   Busy_Out         high whenever not IDLE
//   Done_Out         one-cycle pulse on normal completion
//   Error_Out        sticky configuration error from the last start
//   Trip_Count_Out   round trips completed in the current run
module up_down_counter_controller #(
    parameter int CNT_W = 4
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Start_In,
    input  logic             Abort_In,
    input  logic             Pause_In,
    input  logic [1:0]       Mode_In,
    input  logic [CNT_W-1:0] Low_Limit_In,
    input  logic [CNT_W-1:0] High_Limit_In,
    input  logic [CNT_W-1:0] Cycles_In,
    input  logic [CNT_W-1:0] Count_In,
    output logic             Start_Stopb_Out,
    output logic             Up_Downb_Out,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic             Error_Out,
    output logic [CNT_W-1:0] Trip_Count_Out
);

    typedef enum logic [1:0] {IDLE, SEEK, UP, DOWN} state_t;

    localparam logic [1:0] MODE_UP_ONCE   = 2'b00;
    localparam logic [1:0] MODE_DOWN_ONCE = 2'b01;
    localparam logic [1:0] MODE_PING_PONG = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             en_q, en_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] trip_q, trip_d;

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] trip_inc;
    logic             bad_cfg;

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            low_q    <= '0;
            high_q   <= '0;
            cycles_q <= '0;
            en_q     <= 1'b0;
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            trip_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            low_q    <= low_d;
            high_q   <= high_d;
            cycles_q <= cycles_d;
            en_q     <= en_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            trip_q   <= trip_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        low_d    = low_q;
        high_d   = high_q;
        cycles_d = cycles_q;
        en_d     = en_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        err_d    = err_q;
        trip_d   = trip_q;
        target   = (mode_q == MODE_DOWN_ONCE) ? high_q : low_q;
        trip_inc = trip_q + CNT_W'(1);
        bad_cfg  = (Low_Limit_In >= High_Limit_In) ||
                   ((Mode_In == 2'b11) && (Cycles_In == '0));

        if (state_q == IDLE) begin
            en_d = 1'b0;
            if (Start_In) begin
                mode_d   = Mode_In;
                low_d    = Low_Limit_In;
                high_d   = High_Limit_In;
                cycles_d = Cycles_In;
                trip_d   = '0;
                err_d    = bad_cfg;
                if (!bad_cfg) begin
                    state_d = SEEK;
                end
            end
        end else if (Abort_In) begin
            state_d = IDLE;
            en_d    = 1'b0;
        end else if (Pause_In) begin
            en_d = 1'b0;
        end else begin
            case (state_q)
                SEEK: begin
                    en_d = 1'b1;
                    if (Count_In < target) begin
                        dir_d = 1'b1;
                    end else if (Count_In > target) begin
                        dir_d = 1'b0;
                    end else if (mode_q == MODE_DOWN_ONCE) begin
                        state_d = DOWN;
                        dir_d   = 1'b0;
                    end else begin
                        state_d = UP;
                        dir_d   = 1'b1;
                    end
                end
                UP: begin
                    if (Count_In != high_q) begin
                        en_d  = 1'b1;
                        dir_d = 1'b1;
                    end else if (mode_q == MODE_UP_ONCE) begin
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        en_d    = 1'b1;
                        dir_d   = 1'b0;
                        state_d = DOWN;
                    end
                end
                DOWN: begin
                    if (Count_In != low_q) begin
                        en_d  = 1'b1;
                        dir_d = 1'b0;
                    end else if (mode_q[1] == 1'b0) begin
                        // down-once finishes at the low limit
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        trip_d = trip_inc;
                        if ((mode_q != MODE_PING_PONG) && (trip_inc == cycles_q)) begin
                            en_d    = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            en_d    = 1'b1;
                            dir_d   = 1'b1;
                            state_d = UP;
                        end
                    end
                end
                default: begin
                    en_d    = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign Start_Stopb_Out = en_q;
    assign Up_Downb_Out    = dir_q;
    assign Busy_Out        = busy_q;
    assign Done_Out        = done_q;
    assign Error_Out       = err_q;
    assign Trip_Count_Out  = trip_q;

endmodule

// File: tb/tb_up_down_counter_controller.sv
// Bench for up_down_counter_controller: an external counter model steps on the
// falling edge, and each run's visited count sequence is compared against a
// trajectory computed directly from the limits and mode.
module tb_up_down_counter_controller;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, start = 1'b0, abrt = 1'b0, pause = 1'b0;
    logic [1:0]   mode = '0;
    logic [W-1:0] lo = '0, hi = '0, cyc = '0;
    logic [W-1:0] cnt = '0;
    logic         en, dir, busy, done, err;
    logic [W-1:0] trip;

    int checks = 0;
    int errors = 0;

    up_down_counter_controller #(.CNT_W(W)) dut (
        .Clk_In(clk), .Reset_In(rst), .Start_In(start), .Abort_In(abrt),
        .Pause_In(pause), .Mode_In(mode), .Low_Limit_In(lo),
        .High_Limit_In(hi), .Cycles_In(cyc), .Count_In(cnt),
        .Start_Stopb_Out(en), .Up_Downb_Out(dir), .Busy_Out(busy),
        .Done_Out(done), .Error_Out(err), .Trip_Count_Out(trip)
    );

    // counter model + observers
    logic         load_en = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] m_lo = '0, m_hi = '0;
    int           traj[$];
    bit           rec = 1'b0;
    int           done_cnt = 0;
    int           m_trips = 0;
    bit           seen_hi = 1'b0;

    always @(negedge clk) begin : counter_model
        logic [W-1:0] nv;
        if (done === 1'b1) done_cnt++;
        if (load_en) begin
            cnt <= load_val;
        end else if (en === 1'b1) begin
            nv = dir ? cnt + 1'b1 : cnt - 1'b1;
            cnt <= nv;
            if (rec) traj.push_back(int'(nv));
            if (nv == m_hi) seen_hi = 1'b1;
            else if (nv == m_lo && seen_hi) begin
                m_trips++;
                seen_hi = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int v);
        load_val = v[W-1:0];
        load_en  = 1'b1;
        @(negedge clk);
        #1;
        load_en  = 1'b0;
    endtask

    // One complete run from counter value c0; expected trajectory built from the rules.
    task automatic run_once(input logic [1:0] m, input int l, input int h, input int n,
                            input int c0, input string tag);
        int expq[$];
        int c, t, mism, sz;
        c = c0;
        expq.push_back(c);
        t = (m == 2'b01) ? h : l;
        while (c < t) begin c++; expq.push_back(c); end
        while (c > t) begin c--; expq.push_back(c); end
        if (m == 2'b00) begin
            while (c < h) begin c++; expq.push_back(c); end
        end else if (m == 2'b01) begin
            while (c > l) begin c--; expq.push_back(c); end
        end else begin
            repeat (n) begin
                while (c < h) begin c++; expq.push_back(c); end
                while (c > l) begin c--; expq.push_back(c); end
            end
        end

        preload(c0);
        traj.delete();
        traj.push_back(c0);
        rec = 1'b1;
        done_cnt = 0;
        mode = m; lo = l[W-1:0]; hi = h[W-1:0]; cyc = n[W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, " busy"}, busy, 1);
        check_eq({tag, " err"}, err, 0);
        // scramble configuration mid-run; latched values must be used
        lo = $urandom; hi = $urandom; cyc = $urandom; mode = $urandom;
        for (int i = 0; i < 600 && busy; i++) tick();
        check_eq({tag, " finished"}, busy, 0);
        repeat (3) tick();
        rec = 1'b0;
        check_eq({tag, " done_pulses"}, done_cnt, 1);
        check_eq({tag, " final_count"}, cnt, c);
        check_eq({tag, " trips"}, trip, (m == 2'b11) ? n : 0);
        check_eq({tag, " enable_off"}, en, 0);
        sz = (traj.size() < expq.size()) ? traj.size() : expq.size();
        mism = 0;
        for (int i = 0; i < sz; i++) if (traj[i] != expq[i]) mism++;
        check_eq({tag, " traj_len"}, traj.size(), expq.size());
        check_eq({tag, " traj_mismatch"}, mism, 0);
    endtask

    task automatic bad_start(input logic [1:0] m, input int l, input int h, input int n,
                             input string tag);
        mode = m; lo = l[W-1:0]; hi = h[W-1:0]; cyc = n[W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, " err"}, err, 1);
        check_eq({tag, " busy"}, busy, 0);
        repeat (2) tick();
        check_eq({tag, " enable"}, en, 0);
        check_eq({tag, " err_sticky"}, err, 1);
    endtask

    initial begin
        int l, h, k, i;
        logic d0;
        repeat (2) tick();
        check_eq("rst en", en, 0);
        check_eq("rst dir", dir, 1);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst err", err, 0);
        check_eq("rst trip", trip, 0);
        rst = 1'b0;
        tick();

        run_once(2'b00, 3, 9, 0, 0, "up_once");
        run_once(2'b01, 2, 12, 0, 15, "down_once");
        run_once(2'b11, 4, 6, 2, 4, "round_trips");

        bad_start(2'b00, 7, 7, 0, "equal_limits");
        run_once(2'b00, 1, 2, 0, 5, "clear_err");
        bad_start(2'b11, 2, 9, 0, "zero_cycles");
        bad_start(2'b10, 9, 3, 0, "inverted_limits");
        run_once(2'b11, 0, 15, 1, 15, "full_range");

        for (int r = 0; r < 8; r++) begin
            l = $urandom_range(0, 14);
            h = $urandom_range(l + 1, 15);
            k = $urandom_range(0, 2);
            run_once((k == 2) ? 2'b11 : k[1:0], l, h, $urandom_range(1, 3),
                     $urandom_range(0, 15), "random");
        end

        // ping-pong pause and abort
        preload(0);
        done_cnt = 0;
        m_lo = 4'd0; m_hi = 4'd15;
        mode = 2'b10; lo = 4'd0; hi = 4'd15; cyc = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (i = 0; i < 100 && cnt != 4'd8; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("pause reach8", cnt, 8);
        d0 = dir;
        pause = 1'b1;
        repeat (5) tick();
        check_eq("pause hold", cnt, 8);
        check_eq("pause en", en, 0);
        check_eq("pause busy", busy, 1);
        check_eq("pause dir", dir, d0);
        pause = 1'b0;
        repeat (2) tick();
        check_eq("resume step", cnt, d0 ? 9 : 7);
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        check_eq("abort busy", busy, 0);
        check_eq("abort en", en, 0);
        repeat (2) tick();
        check_eq("abort no_done", done_cnt, 0);

        // ping-pong trip counting with wrap, abort at the high limit
        l = $urandom_range(0, 12);
        h = l + $urandom_range(1, 3);
        k = $urandom_range(14, 20);
        preload(l);
        m_lo = l[W-1:0]; m_hi = h[W-1:0];
        m_trips = 0; seen_hi = 1'b0;
        mode = 2'b10; lo = l[W-1:0]; hi = h[W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (i = 0; i < 2000 && !(m_trips == k && cnt == h[W-1:0]); i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("pingpong reached", m_trips, k);
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        check_eq("pingpong trips", trip, k % 16);
        check_eq("pingpong idle", busy, 0);

        // reset while counting down
        preload(15);
        mode = 2'b01; lo = 4'd2; hi = 4'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (i = 0; i < 100 && cnt != 4'd5; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("midrst reach5", cnt, 5);
        done_cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst en", en, 0);
        check_eq("midrst dir", dir, 1);
        check_eq("midrst busy", busy, 0);
        check_eq("midrst err", err, 0);
        check_eq("midrst trip", trip, 0);
        repeat (3) tick();
        check_eq("midrst hold", cnt, 5);
        check_eq("midrst no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
